// File: rtl/mem_arbiter_if.sv
// Bundle of every signal between mem_arbiter and its neighbours: the fetch
// requester (i_*), the load/store requester (d_*), the memory slave (mem_*)
// and the busy status flag.
//   slave  : arbiter view (requests and memory completion in; grants,
//            responses and the memory request out)
//   master : environment view (requesters and memory model)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              i_valid;
  logic              i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_valid;
  logic              d_ready;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [STRB_W-1:0] d_wstrb;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  i_valid, i_addr,
    input  d_valid, d_we, d_addr, d_wdata, d_wstrb,
    input  mem_ready, mem_rdata,
    output i_ready, i_resp_valid, i_rdata,
    output d_ready, d_resp_valid, d_rdata,
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output busy
  );

  modport master (
    output i_valid, i_addr,
    output d_valid, d_we, d_addr, d_wdata, d_wstrb,
    output mem_ready, mem_rdata,
    input  i_ready, i_resp_valid, i_rdata,
    input  d_ready, d_resp_valid, d_rdata,
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch requester (read-only) and the
// load/store requester. One transaction in flight at a time; the completion
// is routed back to whichever requester owns it.
// Ports:
//   clk   - clock, all logic on posedge
//   rstn  - synchronous active-low reset
//   bus   - mem_arbiter_if.slave: i_* fetch port, d_* load/store port,
//           mem_* memory port, busy status
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, load/store wins over fetch on a conflict
//   defined   : on a conflict the requester not granted last wins
//               (last grant resets to load/store, so the first conflict
//               goes to fetch)
//
// state | meaning
// IDLE  | no transaction; a pending request is accepted combinationally
// BUSY  | mem_valid held with the request fields until mem_ready
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  mem_arbiter_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic              owner_d;       // 1 = load/store owns the current/last transaction
  logic              mem_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [STRB_W-1:0] mem_wstrb_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic d_first;
  logic grant_d;
  logic grant_i;
  logic accept;
  logic store;

`ifdef ARB_ROUND_ROBIN_EN
  // owner_d is updated on every accept and resets to load/store, so it
  // doubles as the last-granted record.
  assign d_first = ~owner_d;
`else
  assign d_first = 1'b1;
`endif

  assign grant_d = bus.d_valid & (~bus.i_valid | d_first);
  assign grant_i = bus.i_valid & ~grant_d;
  assign accept  = (state == IDLE) & (grant_d | grant_i);
  assign store   = grant_d & bus.d_we;

  assign bus.d_ready      = (state == IDLE) & grant_d;
  assign bus.i_ready      = (state == IDLE) & grant_i;
  assign bus.mem_valid    = mem_valid_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wstrb    = mem_wstrb_q;
  assign bus.i_resp_valid = i_resp_q;
  assign bus.d_resp_valid = d_resp_q;
  assign bus.i_rdata      = i_rdata_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.busy         = (state == BUSY);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      owner_d     <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      i_resp_q    <= 1'b0;
      d_resp_q    <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
      case (state)
        IDLE: begin
          // mem_ready arriving here is stray and deliberately ignored
          if (accept) begin
            state       <= BUSY;
            owner_d     <= grant_d;
            mem_valid_q <= 1'b1;
            mem_we_q    <= store;
            mem_addr_q  <= grant_d ? bus.d_addr : bus.i_addr;
            mem_wdata_q <= store ? bus.d_wdata : '0;
            mem_wstrb_q <= store ? bus.d_wstrb : '0;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
            if (owner_d) begin
              d_resp_q  <= 1'b1;
              d_rdata_q <= bus.mem_rdata;
            end else begin
              i_resp_q  <= 1'b1;
              i_rdata_q <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] rdata;
  } resp_t;

  req_t  exp_mem[$];
  resp_t exp_resp[$];
  bit    grants[$];          // 1 = D granted, 0 = I granted
  logic [DW-1:0] mem_model [logic [AW-1:0]];
  logic [DW-1:0] exp_i_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit   m_busy = 0;
  bit   m_last_d = 1;
  int   m_lat = 0;
  req_t m_cur;
  bit   m_cur_d = 0;
  bit   acc_prev = 0;
  bit   rdy_prev = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // 0 none, 1 fetch, 2 load/store
  function automatic int pick(input bit iv, input bit dv, input bit last_d);
    if (iv && dv) begin
`ifdef ARB_ROUND_ROBIN_EN
      return last_d ? 1 : 2;
`else
      return 2;
`endif
    end
    if (dv) return 2;
    if (iv) return 1;
    return 0;
  endfunction

  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_addr = '0;
    bus.d_valid = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
  endtask

  // mode: 0 random, 1 both valid, 2 no requests + stray mem_ready,
  //       3 quiet, 4 fetch 0x100 only, 5 store 0x40 only
  task automatic step(input int mode);
    int w;
    logic [DW-1:0] v;
    @(negedge clk);
    if (rdy_prev) m_busy = 0;
    if (acc_prev) m_busy = 1;
    acc_prev = 0;
    rdy_prev = 0;
    bus.mem_ready = 0;
    bus.mem_rdata = $urandom;
    if (m_busy) begin
      if (m_lat == 0) begin
        bus.mem_ready = 1;
        rdy_prev = 1;
        if (m_cur.we) begin
          v = rd(m_cur.addr);
          for (int b = 0; b < SW; b++)
            if (m_cur.wstrb[b]) v[8*b +: 8] = m_cur.wdata[8*b +: 8];
          mem_model[m_cur.addr] = v;
        end else begin
          bus.mem_rdata = rd(m_cur.addr);
        end
        exp_resp.push_back('{is_d: m_cur_d, rdata: bus.mem_rdata});
      end else begin
        m_lat--;
      end
    end else if (mode == 2 || (mode == 0 && $urandom_range(0, 7) == 0)) begin
      bus.mem_ready = 1;
    end

    bus.i_valid = (mode == 1 || mode == 4) ? 1'b1 : (mode == 0 ? 1'($urandom_range(0, 1)) : 1'b0);
    bus.d_valid = (mode == 1 || mode == 5) ? 1'b1 : (mode == 0 ? 1'($urandom_range(0, 1)) : 1'b0);
    bus.i_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    bus.d_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    bus.d_we    = 1'($urandom_range(0, 1));
    bus.d_wdata = $urandom;
    bus.d_wstrb = 4'($urandom_range(0, 15));
    if (mode == 4) bus.i_addr = 32'h100;
    if (mode == 5) begin
      bus.d_we = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'h1234_5678; bus.d_wstrb = 4'hF;
    end
    #1;
    w = m_busy ? 0 : pick(bus.i_valid, bus.d_valid, m_last_d);
    check("i_ready", bus.i_ready, w == 1);
    check("d_ready", bus.d_ready, w == 2);
    if (w != 0) begin
      m_cur_d    = (w == 2);
      m_last_d   = m_cur_d;
      m_cur.we   = m_cur_d & bus.d_we;
      m_cur.addr = m_cur_d ? bus.d_addr : bus.i_addr;
      m_cur.wdata = m_cur.we ? bus.d_wdata : '0;
      m_cur.wstrb = m_cur.we ? bus.d_wstrb : '0;
      exp_mem.push_back(m_cur);
      grants.push_back(m_cur_d);
      acc_prev = 1;
      m_lat = $urandom_range(0, 2);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    idle_inputs();
    exp_mem.delete(); exp_resp.delete(); grants.delete();
    exp_i_rdata = '0; exp_d_rdata = '0;
    m_busy = 0; m_last_d = 1; acc_prev = 0; rdy_prev = 0; m_lat = 0;
    @(negedge clk);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_i_resp", bus.i_resp_valid, 0);
    check("rst_d_resp", bus.d_resp_valid, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_wstrb", bus.mem_wstrb, 0);
    check("rst_i_rdata", bus.i_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    rstn = 1;
  endtask

  // monitor / scoreboard
  initial begin
    resp_t r;
    forever begin
      @(posedge clk);
      #2;
      if (rstn) begin
        if (bus.i_resp_valid || bus.d_resp_valid) begin
          if (exp_resp.size() == 0 || exp_mem.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got i=%0b d=%0b expected none at %0t",
                     bus.i_resp_valid, bus.d_resp_valid, $time);
          end else begin
            r = exp_resp.pop_front();
            void'(exp_mem.pop_front());
            check("resp_d", bus.d_resp_valid, r.is_d);
            check("resp_i", bus.i_resp_valid, !r.is_d);
            if (r.is_d) exp_d_rdata = r.rdata;
            else        exp_i_rdata = r.rdata;
          end
        end
        check("i_rdata", bus.i_rdata, exp_i_rdata);
        check("d_rdata", bus.d_rdata, exp_d_rdata);
        check("busy", bus.busy, exp_mem.size() != 0);
        check("mem_valid", bus.mem_valid, exp_mem.size() != 0);
        if (bus.mem_valid && exp_mem.size() != 0) begin
          check("mem_addr", bus.mem_addr, exp_mem[0].addr);
          check("mem_we", bus.mem_we, exp_mem[0].we);
          check("mem_wstrb", bus.mem_wstrb, exp_mem[0].wstrb);
          if (exp_mem[0].we) check("mem_wdata", bus.mem_wdata, exp_mem[0].wdata);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_g;
    int n;
    idle_inputs();
    mem_model[32'h100] = 32'hDEAD_BEEF;
    do_reset();

    // conflict: both requesters valid for 4 grants
    n = 0;
    while (grants.size() < 4 && n < 60) begin step(1); n++; end
    check("conflict_count", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_g = (k % 2) == 1;
`else
      exp_g = 1'b1;
`endif
      check("conflict_grant", grants[k], exp_g);
    end
    for (int k = 0; k < 6; k++) step(3);

    // fetch alone, then store alone
    step(4);
    for (int k = 0; k < 5; k++) step(3);
    check("fetch_rdata", bus.i_rdata, 32'hDEAD_BEEF);
    step(5);
    for (int k = 0; k < 5; k++) step(3);
    check("store_merged", mem_model[32'h40], 32'h1234_5678);

    // randomized traffic
    for (int k = 0; k < 600; k++) step(0);
    for (int k = 0; k < 6; k++) step(3);

    // reset in the middle of a transaction
    n = 0;
    while (!acc_prev && n < 50) begin step(0); n++; end
    check("pre_rst_accept", acc_prev, 1);
    m_lat = 10;
    step(3);
    check("pre_rst_mem_valid", bus.mem_valid, 1);
    do_reset();
    for (int k = 0; k < 4; k++) step(2);
    step(3);
    check("post_rst_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
